// File: rtl/mem_port_arbiter.sv
// Byte-wide RAM port arbiter: IF fetch vs MEM load/store, sequenced as little-endian bursts.
// Optional fetch abort on branch redirect is enabled by defining MEM_PORT_IF_ABORT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter bit IDLE_PRIO_MEM = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [2:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic              if_stall_req,
    output logic              mem_stall_req,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
`ifdef MEM_PORT_IF_ABORT_EN
    ,
    input  logic              if_abort
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IF_RD  = 3'd1,
        S_MEM_RD = 3'd2,
        S_MEM_WR = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [2:0]        n_q, n_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              owner_mem_q, owner_mem_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;

    logic              abort_w;
    logic              if_ok;
    logic [2:0]        len_dec;
    logic [2:0]        next_k;
    logic [1:0]        cap_idx;

`ifdef MEM_PORT_IF_ABORT_EN
    assign abort_w = if_abort;
`else
    assign abort_w = 1'b0;
`endif

    // Only 1 and 2 are honoured as short lengths; everything else is a word.
    assign len_dec = (mem_len == 3'd1 || mem_len == 3'd2) ? mem_len : 3'd4;
    assign next_k  = k_q + 3'd1;
    assign cap_idx = 2'(k_q - 3'd1);
    assign if_ok   = if_req && !abort_w;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        n_d         = n_q;
        base_d      = base_q;
        owner_mem_d = owner_mem_q;
        asm_d       = asm_q;
        wdata_d     = wdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        ram_a_d     = ram_a_q;
        ram_wr_d    = 1'b0;
        ram_dout_d  = ram_dout_q;

        case (state_q)
            S_IDLE: begin
                if (mem_req && (IDLE_PRIO_MEM || !if_ok)) begin
                    owner_mem_d = 1'b1;
                    n_d         = len_dec;
                    base_d      = mem_addr;
                    wdata_d     = mem_wdata;
                    k_d         = 3'd0;
                    asm_d       = 32'd0;
                    ram_a_d     = mem_addr;
                    if (mem_we) begin
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata[7:0];
                        state_d    = S_MEM_WR;
                    end else begin
                        state_d    = S_MEM_RD;
                    end
                end else if (if_ok) begin
                    owner_mem_d = 1'b0;
                    n_d         = 3'd4;
                    base_d      = if_addr;
                    k_d         = 3'd0;
                    asm_d       = 32'd0;
                    ram_a_d     = if_addr;
                    state_d     = S_IF_RD;
                end
            end

            S_IF_RD, S_MEM_RD: begin
                if (state_q == S_IF_RD && abort_w) begin
                    k_d     = 3'd0;
                    state_d = S_IDLE;
                end else begin
                    // RAM data lags the address by one cycle, so byte k-1 arrives while k is driven.
                    if (k_q != 3'd0) begin
                        asm_d[{cap_idx, 3'b000} +: 8] = ram_din;
                    end
                    if (k_q == n_q) begin
                        state_d = S_DONE;
                        if (owner_mem_q) begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = asm_d;
                        end else begin
                            if_done_d   = 1'b1;
                            if_data_d   = asm_d;
                        end
                    end else begin
                        k_d = next_k;
                        if (next_k < n_q) begin
                            ram_a_d = base_q + ADDR_W'(next_k);
                        end
                    end
                end
            end

            S_MEM_WR: begin
                if (next_k < n_q) begin
                    k_d        = next_k;
                    ram_a_d    = base_q + ADDR_W'(next_k);
                    ram_wr_d   = 1'b1;
                    ram_dout_d = wdata_q[{next_k[1:0], 3'b000} +: 8];
                end else begin
                    mem_done_d = 1'b1;
                    state_d    = S_DONE;
                end
            end

            // One dead cycle lets the requester drop req before the next arbitration.
            S_DONE: begin
                k_d     = 3'd0;
                state_d = S_IDLE;
            end

            default: begin
                k_d     = 3'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= 3'd0;
            n_q         <= 3'd0;
            base_q      <= '0;
            owner_mem_q <= 1'b0;
            asm_q       <= 32'd0;
            wdata_q     <= 32'd0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
            ram_a_q     <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            n_q         <= n_d;
            base_q      <= base_d;
            owner_mem_q <= owner_mem_d;
            asm_q       <= asm_d;
            wdata_q     <= wdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            ram_a_q     <= ram_a_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
        end
    end

    assign if_done       = if_done_q;
    assign mem_done      = mem_done_q;
    assign if_data       = if_data_q;
    assign mem_rdata     = mem_rdata_q;
    assign ram_a         = ram_a_q;
    assign ram_wr        = ram_wr_q;
    assign ram_dout      = ram_dout_q;
    assign if_stall_req  = if_req && !if_done_q;
    assign mem_stall_req = mem_req && !mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of the port.
// Define MEM_PORT_IF_ABORT_EN to also exercise the fetch-abort input.
module tb_mem_port_arbiter;

    localparam int AW       = 32;
    localparam bit PRIO_MEM = 1'b1;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [31:0]   if_data;
    logic          mem_req;
    logic          mem_we;
    logic [2:0]    mem_len;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_done;
    logic [31:0]   mem_rdata;
    logic          if_stall_req;
    logic          mem_stall_req;
    logic [AW-1:0] ram_a;
    logic          ram_wr;
    logic [7:0]    ram_dout;
    logic [7:0]    ram_din;
`ifdef MEM_PORT_IF_ABORT_EN
    logic          if_abort;
`endif

    mem_port_arbiter #(.ADDR_W(AW), .IDLE_PRIO_MEM(PRIO_MEM)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_done      (if_done),
        .if_data      (if_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_len      (mem_len),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_done     (mem_done),
        .mem_rdata    (mem_rdata),
        .if_stall_req (if_stall_req),
        .mem_stall_req(mem_stall_req),
        .ram_a        (ram_a),
        .ram_wr       (ram_wr),
        .ram_dout     (ram_dout),
        .ram_din      (ram_din)
`ifdef MEM_PORT_IF_ABORT_EN
        ,
        .if_abort     (if_abort)
`endif
    );

    always #5 clk = ~clk;

    // RAM environment (aliased to 4 KiB) and the model's view of the same memory.
    logic [7:0] ram     [0:4095];
    logic [7:0] ref_mem [0:4095];

    always @(posedge clk) begin
        if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
        ram_din <= ram[ram_a[11:0]];
    end

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_if_data;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int len_bytes(input logic [2:0] len);
        return (len == 3'd1 || len == 3'd2) ? int'(len) : 4;
    endfunction

    // Called at the start of the accept cycle with the winner's request already raised.
    task automatic do_burst(input bit is_mem, input logic [31:0] addr, input int n,
                            input bit we, input logic [31:0] wdata, input bit other_req);
        int          d;
        logic [31:0] exp_data;
        logic [11:0] idx;
        logic        own_done, oth_done, own_stall, oth_stall;
        d        = we ? n + 1 : n + 2;
        exp_data = 32'd0;
        for (int i = 0; i < n; i++) begin
            idx = 12'(addr + 32'(i));
            if (!we) exp_data[8*i +: 8] = ref_mem[idx];
        end
        for (int c = 0; c <= d; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= n) begin
                check_val("ram_a", ram_a, addr + 32'(c - 1));
                check_val("ram_wr", 32'(ram_wr), 32'(we));
                if (we) check_val("ram_dout", 32'(ram_dout), 32'(wdata[8*(c-1) +: 8]));
            end else begin
                check_val("ram_wr_quiet", 32'(ram_wr), 32'd0);
            end
            own_done  = is_mem ? mem_done : if_done;
            oth_done  = is_mem ? if_done : mem_done;
            own_stall = is_mem ? mem_stall_req : if_stall_req;
            oth_stall = is_mem ? if_stall_req : mem_stall_req;
            check_val("done", 32'(own_done), 32'(c == d));
            check_val("other_done", 32'(oth_done), 32'd0);
            check_val("stall", 32'(own_stall), 32'(c != d));
            check_val("other_stall", 32'(oth_stall), 32'(other_req));
            if (!is_mem && c == d) exp_if_data = exp_data;
            check_val("if_data", if_data, exp_if_data);
            if (is_mem && !we && c == d) check_val("mem_rdata", mem_rdata, exp_data);
            @(posedge clk);
            #1;
            if (c == 0) begin
                if (is_mem) begin
                    mem_addr  = $urandom;
                    mem_wdata = $urandom;
                    mem_len   = 3'($urandom_range(0, 7));
                    mem_we    = 1'($urandom_range(0, 1));
                end else begin
                    if_addr = $urandom;
                end
            end
            if (c == d) begin
                if (is_mem) mem_req = 1'b0;
                else        if_req  = 1'b0;
            end
        end
        if (we) begin
            for (int i = 0; i < n; i++) begin
                idx = 12'(addr + 32'(i));
                ref_mem[idx] = wdata[8*i +: 8];
            end
        end
        $display("txn %s addr=%h n=%0d we=%0d data=%h", is_mem ? "mem" : "if ",
                 addr, n, we, we ? wdata : exp_data);
    endtask

    task automatic set_mem(input logic [31:0] a, input logic [2:0] len, input bit we,
                           input logic [31:0] wd);
        mem_req   = 1'b1;
        mem_addr  = a;
        mem_len   = len;
        mem_we    = we;
        mem_wdata = wd;
    endtask

    initial begin
        logic [7:0]  v;
        logic [31:0] a_if, a_mem, wd;
        logic [2:0]  len;
        bit          we;
        int          mode;

        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = 3'd0; mem_addr = '0; mem_wdata = 32'd0;
`ifdef MEM_PORT_IF_ABORT_EN
        if_abort = 1'b0;
`endif
        exp_if_data = 32'd0;
        for (int i = 0; i < 4096; i++) begin
            v = 8'($urandom);
            if (i == 'h100) v = 8'h13;
            if (i >= 'h101 && i <= 'h103) v = 8'h00;
            if (i == 'h010) v = 8'hF0;
            ram[i] <= v;
            ref_mem[i] = v;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_if_done", 32'(if_done), 32'd0);
        check_val("rst_mem_done", 32'(mem_done), 32'd0);
        check_val("rst_if_data", if_data, 32'd0);
        check_val("rst_mem_rdata", mem_rdata, 32'd0);
        check_val("rst_ram_a", ram_a, 32'd0);
        check_val("rst_ram_wr", 32'(ram_wr), 32'd0);
        check_val("rst_ram_dout", 32'(ram_dout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Instruction fetch of 0x00000013.
        if_req = 1'b1; if_addr = 32'h100;
        do_burst(1'b0, 32'h100, 4, 1'b0, 32'd0, 1'b0);
        check_val("fetch_word", if_data, 32'h0000_0013);

        // Halfword store leaves the third byte alone.
        set_mem(32'h2000, 3'd2, 1'b1, 32'hAABB_CCDD);
        do_burst(1'b1, 32'h2000, 2, 1'b1, 32'hAABB_CCDD, 1'b0);
        check_val("store_b0", 32'(ram[12'h000]), 32'h0000_00DD);
        check_val("store_b1", 32'(ram[12'h001]), 32'h0000_00CC);
        check_val("store_untouched", 32'(ram[12'h002]), 32'(ref_mem[12'h002]));

        // Simultaneous requests.
        a_if = 32'h0000_0400;
        if_req = 1'b1; if_addr = a_if;
        set_mem(32'h10, 3'd1, 1'b0, 32'd0);
        if (PRIO_MEM) begin
            do_burst(1'b1, 32'h10, 1, 1'b0, 32'd0, 1'b1);
            check_val("prio_rdata", mem_rdata, 32'h0000_00F0);
            do_burst(1'b0, a_if, 4, 1'b0, 32'd0, 1'b0);
        end else begin
            do_burst(1'b0, a_if, 4, 1'b0, 32'd0, 1'b1);
            do_burst(1'b1, 32'h10, 1, 1'b0, 32'd0, 1'b0);
        end

        // Address wrap at the top of the space.
        if_req = 1'b1; if_addr = 32'hFFFF_FFFE;
        do_burst(1'b0, 32'hFFFF_FFFE, 4, 1'b0, 32'd0, 1'b0);

        // Reset in cycle 2 of a fetch abandons it.
        if_req = 1'b1; if_addr = 32'h100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; if_req = 1'b0;
        exp_if_data = 32'd0;
        @(negedge clk);
        check_val("mid_rst_if_data", if_data, 32'd0);
        check_val("mid_rst_mem_rdata", mem_rdata, 32'd0);
        check_val("mid_rst_ram_a", ram_a, 32'd0);
        check_val("mid_rst_ram_wr", 32'(ram_wr), 32'd0);
        check_val("mid_rst_ram_dout", 32'(ram_dout), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check_val("mid_rst_no_done", 32'(if_done), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h100;
        do_burst(1'b0, 32'h100, 4, 1'b0, 32'd0, 1'b0);

`ifdef MEM_PORT_IF_ABORT_EN
        // Branch redirect aborts a fetch; the waiting load goes next.
        if_req = 1'b1; if_addr = 32'h200;
        @(posedge clk); #1;
        set_mem(32'h100, 3'd4, 1'b0, 32'd0);
        @(posedge clk); #1;
        if_abort = 1'b1; if_req = 1'b0;
        @(negedge clk);
        check_val("abort_ram_a", ram_a, 32'h201);
        @(posedge clk); #1;
        if_abort = 1'b0;
        do_burst(1'b1, 32'h100, 4, 1'b0, 32'd0, 1'b0);
`endif

        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            mode  = $urandom_range(0, 2);
            a_if  = $urandom;
            a_mem = $urandom;
            wd    = $urandom;
            len   = 3'($urandom_range(0, 7));
            we    = 1'($urandom_range(0, 1));
            if (mode == 0) begin
                if_req = 1'b1; if_addr = a_if;
                do_burst(1'b0, a_if, 4, 1'b0, 32'd0, 1'b0);
            end else if (mode == 1) begin
                set_mem(a_mem, len, we, wd);
                do_burst(1'b1, a_mem, len_bytes(len), we, wd, 1'b0);
            end else begin
                if_req = 1'b1; if_addr = a_if;
                set_mem(a_mem, len, we, wd);
                if (PRIO_MEM) begin
                    do_burst(1'b1, a_mem, len_bytes(len), we, wd, 1'b1);
                    do_burst(1'b0, a_if, 4, 1'b0, 32'd0, 1'b0);
                end else begin
                    do_burst(1'b0, a_if, 4, 1'b0, 32'd0, 1'b1);
                    do_burst(1'b1, a_mem, len_bytes(len), we, wd, 1'b0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
